socetlib_fifo_ext: RTL and testbench
====================================

Name: socetlib_fifo_ext

Overview:
- Parametrised successor to the team's basic synchronous FIFO.
- Generalised data width; any DEPTH >= 2 (non-power-of-2 allowed).
- Full-and-read pass-through: a write is accepted while full if a read fires the same cycle.
- Adds optional registered read port, programmable almost-full/almost-empty flags, free-slot count and a high-water mark.
- Sits between producer/consumer pipeline stages in the tensor-core datapath and feeds flow control upstream.

Parameters:
- DATA_W, 8, width of one entry in bits.
- DEPTH, 8, number of entries; any integer >= 2.
- REG_OUT, 0, 0 = first-word-fall-through combinational rdata; 1 = registered rdata with 1-cycle latency.
- AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset; synchronous, active-high.
- clear  in  1  synchronous flush.
- WEN  in  1  write request.
- REN  in  1  read request.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- overrun  out  1  sticky; a write was dropped.
- underrun  out  1  sticky; a read was attempted while empty.
- count  out  CNT_W  occupancy, where CNT_W = $clog2(DEPTH+1).
- free_count  out  CNT_W  DEPTH - count.
- high_water  out  CNT_W  maximum count since the last RST or clear.

Behaviour:
- Priority: RST > clear > WEN/REN.
- RST: pointers, count, overrun, underrun, high_water and registered rdata all go to 0.
  - Post-reset outputs: empty=1, full=0, almost_empty=1, almost_full=0, free_count=DEPTH.
  - Storage contents need not be reset.
- clear: same effect as RST on every state element except storage. WEN/REN are ignored in that cycle.
- Fire conditions:
  - rd_fire = REN && !empty.
  - wr_fire = WEN && (!full || rd_fire).
- Write: on wr_fire, mem[wr_ptr] <= wdata and wr_ptr advances.
- Read: on rd_fire, rd_ptr advances.
- Pointer wrap: pointers are ADDR_W = $clog2(DEPTH) bits. The value DEPTH-1 wraps to 0 explicitly; there is no power-of-2 rollover assumption.
- count_next = count + wr_fire - rd_fire. It never leaves 0..DEPTH.
- Full with WEN && REN: both fire, count is unchanged and overrun stays clear.
- Empty with WEN && REN: the write fires, the read does not, underrun sets, count becomes 1. There is no bypass of wdata to rdata.
- Error flags:
  - overrun sets when WEN && full && !REN.
  - underrun sets when REN && empty.
  - Both are sticky until RST or clear.
- Flag timing: full, empty, almost_full, almost_empty and free_count are combinational from the registered count, so they are glitch-free and update the cycle after the causing edge.
- high_water_next = max(high_water, count_next), registered.
- REG_OUT=0: rdata = mem[rd_ptr] continuously. The value is undefined/stale while empty.
- REG_OUT=1: on rd_fire, rdata <= mem[rd_ptr]. Data is valid the cycle after REN and holds until the next rd_fire.
- Elaboration-time $error for any of:
  - DEPTH < 2;
  - AF_THRESH outside 1..DEPTH;
  - AE_THRESH outside 0..DEPTH-1;
  - REG_OUT not in {0,1}.

Decomposition:
- Package socetlib_fifo_pkg holds:
  - function cnt_w(depth), returning $clog2(depth+1);
  - function addr_w(depth), returning max(1, $clog2(depth));
  - the typedef-free parameter-check macros.
- Sub-module socetlib_wrap_ctr (params MAX, W; ports CLK, RST, clear, inc, value) implements the wrap-at-MAX-1 pointer. It is instantiated twice, as wr_ptr and rd_ptr.
- Storage, count and flag logic stay in the top module.

Test Plan:
- Reset, then DEPTH=5 and DATA_W=16: write 0x0001..0x0005 -> full=1, count=5, free_count=0. Then read 5 -> data returns in order, empty=1.
- DEPTH=5 full, then WEN=REN=1 for 7 cycles with incrementing data -> count stays 5, overrun=0, reads continue in order across pointer wrap 4->0.
- DEPTH=5, empty, WEN=REN=1 with wdata=0xAAAA -> underrun=1, count=1. Next cycle rdata=0xAAAA (REG_OUT=0).
- REG_OUT=1: write 0x11, 0x22, then REN pulse -> rdata=0x11 one cycle after the REN edge and holds until the next REN. Next REN gives 0x22.
- AF_THRESH=4, AE_THRESH=1, DEPTH=5: fill 0->5 -> almost_empty deasserts at count 2, almost_full asserts at count 4. Drain 3 -> high_water stays 5.
- With count=3 and overrun=1, assert clear with WEN=1 -> next cycle count=0, overrun=0, high_water=0, no write stored. Assert RST mid-burst -> same result.

Source files
------------

// File: rtl/socetlib_fifo_ext_pkg.sv
// Shared sizing helpers and the parameter-check macro for socetlib FIFOs.
`ifndef SOCETLIB_FIFO_PKG_SV
`define SOCETLIB_FIFO_PKG_SV

`define SOCETLIB_FIFO_CHECK(lbl, cond, msg) \
  if (!(cond)) begin : lbl \
    $error(msg); \
  end

package socetlib_fifo_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_w(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

endpackage

`endif

// File: rtl/socetlib_fifo_ext_if.sv
// Producer/consumer-facing bundle of the extended FIFO.
interface socetlib_fifo_ext_if
  import socetlib_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic              clear;
  logic              WEN;
  logic              REN;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overrun;
  logic              underrun;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  free_count;
  logic [CNT_W-1:0]  high_water;

  modport master (
    output clear, WEN, REN, wdata,
    input  rdata, full, empty, almost_full, almost_empty,
           overrun, underrun, count, free_count, high_water
  );

  modport slave (
    input  clear, WEN, REN, wdata,
    output rdata, full, empty, almost_full, almost_empty,
           overrun, underrun, count, free_count, high_water
  );
endinterface

// File: rtl/socetlib_fifo_ext_wrap_ctr.sv
// Pointer counter that wraps explicitly at MAX-1, so any MAX works.
module socetlib_wrap_ctr #(
  parameter int MAX = 8,
  parameter int W   = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);
  always_ff @(posedge CLK) begin
    if (RST || clear)
      value <= '0;
    else if (inc)
      value <= (value == W'(MAX - 1)) ? '0 : value + 1'b1;
  end
endmodule

// File: rtl/socetlib_fifo_ext.sv
// Synchronous FIFO with pass-through on full, optional registered read,
// threshold flags, free-slot count and a high-water mark.
module socetlib_fifo_ext
  import socetlib_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int REG_OUT   = 0,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input logic               CLK,
  input logic               RST,
  socetlib_fifo_ext_if.slave bus
);
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam int ADDR_W = addr_w(DEPTH);

  `SOCETLIB_FIFO_CHECK(g_chk_depth, DEPTH >= 2, "socetlib_fifo_ext: DEPTH must be >= 2")
  `SOCETLIB_FIFO_CHECK(g_chk_af, (AF_THRESH >= 1) && (AF_THRESH <= DEPTH), "socetlib_fifo_ext: AF_THRESH outside 1..DEPTH")
  `SOCETLIB_FIFO_CHECK(g_chk_ae, (AE_THRESH >= 0) && (AE_THRESH <= DEPTH - 1), "socetlib_fifo_ext: AE_THRESH outside 0..DEPTH-1")
  `SOCETLIB_FIFO_CHECK(g_chk_reg, (REG_OUT == 0) || (REG_OUT == 1), "socetlib_fifo_ext: REG_OUT must be 0 or 1")

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_next, high_water;
  logic              full, empty, rd_fire, wr_fire;
  logic              overrun, underrun;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_fire = bus.REN && !empty;
  // A full FIFO still accepts a write when a read frees a slot this cycle.
  assign wr_fire = bus.WEN && (!full || rd_fire);
  assign count_next = count + CNT_W'(wr_fire) - CNT_W'(rd_fire);

  socetlib_wrap_ctr #(.MAX(DEPTH), .W(ADDR_W)) u_wr_ptr (
    .CLK(CLK), .RST(RST), .clear(bus.clear), .inc(wr_fire), .value(wr_ptr)
  );

  socetlib_wrap_ctr #(.MAX(DEPTH), .W(ADDR_W)) u_rd_ptr (
    .CLK(CLK), .RST(RST), .clear(bus.clear), .inc(rd_fire), .value(rd_ptr)
  );

  always_ff @(posedge CLK) begin
    if (!RST && !bus.clear && wr_fire)
      mem[wr_ptr] <= bus.wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST || bus.clear) begin
      count      <= '0;
      high_water <= '0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      count <= count_next;
      if (count_next > high_water)
        high_water <= count_next;
      if (bus.WEN && full && !bus.REN)
        overrun <= 1'b1;
      if (bus.REN && empty)
        underrun <= 1'b1;
    end
  end

  generate
    if (REG_OUT == 1) begin : g_reg_out
      logic [DATA_W-1:0] rdata_q;
      always_ff @(posedge CLK) begin
        if (RST || bus.clear)
          rdata_q <= '0;
        else if (rd_fire)
          rdata_q <= mem[rd_ptr];
      end
      assign bus.rdata = rdata_q;
    end else begin : g_fwft
      assign bus.rdata = mem[rd_ptr];
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= CNT_W'(AF_THRESH));
  assign bus.almost_empty = (count <= CNT_W'(AE_THRESH));
  assign bus.overrun      = overrun;
  assign bus.underrun     = underrun;
  assign bus.count        = count;
  assign bus.free_count   = CNT_W'(DEPTH) - count;
  assign bus.high_water   = high_water;
endmodule

// File: tb/tb_socetlib_fifo_ext.sv
// Directed bench: FWFT instance (ua) and registered-read instance (ub), DEPTH=5.
module tb_socetlib_fifo_ext;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  always #5 CLK = ~CLK;

  socetlib_fifo_ext_if #(.DATA_W(16), .DEPTH(5)) ia ();
  socetlib_fifo_ext_if #(.DATA_W(16), .DEPTH(5)) ib ();

  socetlib_fifo_ext #(.DATA_W(16), .DEPTH(5), .REG_OUT(0), .AF_THRESH(4), .AE_THRESH(1)) ua (
    .CLK(CLK), .RST(RST), .bus(ia)
  );

  socetlib_fifo_ext #(.DATA_W(16), .DEPTH(5), .REG_OUT(1), .AF_THRESH(4), .AE_THRESH(1)) ub (
    .CLK(CLK), .RST(RST), .bus(ib)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv_a(input logic c, input logic w, input logic r, input logic [15:0] d);
    ia.clear = c; ia.WEN = w; ia.REN = r; ia.wdata = d;
  endtask

  task automatic drv_b(input logic w, input logic r, input logic [15:0] d);
    ib.clear = 1'b0; ib.WEN = w; ib.REN = r; ib.wdata = d;
  endtask

  initial begin
    #100000;
    if (!done) begin
      errors++;
      $error("FAIL timeout: directed sequence did not complete");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    drv_a(0, 0, 0, 16'h0);
    drv_b(0, 0, 16'h0);
    tick();
    tick();
    chk("rst_count", ia.count, 0);
    chk("rst_empty", ia.empty, 1);
    chk("rst_full", ia.full, 0);
    chk("rst_ae", ia.almost_empty, 1);
    chk("rst_af", ia.almost_full, 0);
    chk("rst_free", ia.free_count, 5);
    chk("rst_hw", ia.high_water, 0);
    chk("rst_ovr", ia.overrun, 0);
    chk("rst_udr", ia.underrun, 0);
    chk("rst_rdata_reg", ib.rdata, 0);
    RST = 1'b0;

    for (int i = 1; i <= 5; i++) begin
      drv_a(0, 1, 0, 16'(i));
      tick();
      chk("fill_count", ia.count, i);
      chk("fill_ae", ia.almost_empty, (i <= 1));
      chk("fill_af", ia.almost_full, (i >= 4));
    end
    chk("fill_full", ia.full, 1);
    chk("fill_free", ia.free_count, 0);
    chk("fill_hw", ia.high_water, 5);

    for (int i = 1; i <= 5; i++) begin
      drv_a(0, 0, 1, 16'h0);
      chk("drain_rdata", ia.rdata, i);
      tick();
      if (i == 3) chk("drain3_hw", ia.high_water, 5);
    end
    chk("drain_empty", ia.empty, 1);
    chk("drain_count", ia.count, 0);
    chk("drain_hw", ia.high_water, 5);
    chk("drain_udr", ia.underrun, 0);

    for (int i = 0; i < 5; i++) begin
      drv_a(0, 1, 0, 16'h10 + 16'(i));
      tick();
    end
    for (int k = 0; k < 7; k++) begin
      drv_a(0, 1, 1, 16'h20 + 16'(k));
      chk("pass_rdata", ia.rdata, (k < 5) ? (16'h10 + k) : (16'h20 + k - 5));
      tick();
      chk("pass_count", ia.count, 5);
      chk("pass_ovr", ia.overrun, 0);
    end

    drv_a(0, 1, 0, 16'hBEEF);
    tick();
    chk("ovr_set", ia.overrun, 1);
    chk("ovr_count", ia.count, 5);
    chk("ovr_rdata", ia.rdata, 16'h22);

    drv_a(0, 0, 1, 16'h0);
    tick();
    tick();
    chk("pre_clr_count", ia.count, 3);
    chk("pre_clr_ovr", ia.overrun, 1);
    drv_a(1, 1, 0, 16'hDEAD);
    tick();
    chk("clr_count", ia.count, 0);
    chk("clr_ovr", ia.overrun, 0);
    chk("clr_hw", ia.high_water, 0);
    chk("clr_empty", ia.empty, 1);

    drv_a(0, 1, 1, 16'hAAAA);
    tick();
    drv_a(0, 0, 0, 16'h0);
    chk("udr_set", ia.underrun, 1);
    chk("udr_count", ia.count, 1);
    chk("udr_rdata", ia.rdata, 16'hAAAA);
    chk("udr_hw", ia.high_water, 1);

    drv_a(0, 1, 0, 16'h0101);
    tick();
    drv_a(0, 1, 0, 16'h0202);
    tick();
    chk("burst_count", ia.count, 3);
    RST = 1'b1;
    drv_a(0, 1, 0, 16'h0303);
    tick();
    RST = 1'b0;
    drv_a(0, 0, 0, 16'h0);
    chk("rstb_count", ia.count, 0);
    chk("rstb_udr", ia.underrun, 0);
    chk("rstb_hw", ia.high_water, 0);
    chk("rstb_empty", ia.empty, 1);

    drv_b(1, 0, 16'h0011);
    tick();
    drv_b(1, 0, 16'h0022);
    tick();
    drv_b(0, 0, 16'h0);
    chk("reg_before", ib.rdata, 0);
    drv_b(0, 1, 16'h0);
    tick();
    drv_b(0, 0, 16'h0);
    chk("reg_first", ib.rdata, 16'h11);
    tick();
    tick();
    chk("reg_hold", ib.rdata, 16'h11);
    drv_b(0, 1, 16'h0);
    tick();
    drv_b(0, 0, 16'h0);
    chk("reg_second", ib.rdata, 16'h22);
    chk("reg_empty", ib.empty, 1);
    drv_b(0, 1, 16'h0);
    tick();
    drv_b(0, 0, 16'h0);
    chk("reg_udr", ib.underrun, 1);
    chk("reg_udr_hold", ib.rdata, 16'h22);

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
